// File: rtl/cdc_xfer_arbiter_pkg.sv
// Shared types and defaults for the clk_a-side transfer arbiter.
package cdc_xfer_pkg;

  localparam int NUM_REQ_DEFAULT     = 4;
  localparam int DATA_W_DEFAULT      = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int TIMEOUT_W_DEFAULT   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } xfer_state_t;

  // Width of a requester index; never below one bit.
  function automatic int gnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_xfer_arbiter_if.sv
// Requester and crossing-handshake signals of the transfer arbiter.
interface cdc_xfer_arbiter_if
  import cdc_xfer_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT
);
  localparam int GNT_W = gnt_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      xfer_req;
  logic [DATA_W-1:0]         xfer_data;
  logic                      xfer_ack;
  logic                      busy;
  logic [GNT_W-1:0]          grant_idx;
  logic                      timeout_err;

  modport master (
    output req_valid, req_data, xfer_ack,
    input  req_ready, xfer_req, xfer_data, busy, grant_idx, timeout_err
  );

  modport slave (
    input  req_valid, req_data, xfer_ack,
    output req_ready, xfer_req, xfer_data, busy, grant_idx, timeout_err
  );

endinterface

// File: rtl/cdc_xfer_arbiter_sync_bit.sv
// Multi-flop single-bit synchronizer with asynchronous active-low clear.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/cdc_xfer_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack crossing into clk_b.
// Optional watchdog enabled by defining CDC_XFER_TIMEOUT_EN.
module cdc_xfer_arbiter
  import cdc_xfer_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEFAULT,
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int TIMEOUT_W   = TIMEOUT_W_DEFAULT
) (
  input  logic                clk_a,
  input  logic                rst_a_n,
  cdc_xfer_arbiter_if.slave   bus
);

  localparam int GNT_W = gnt_width(NUM_REQ);

  logic              ack_s;
  xfer_state_t       state_reg, state_next;
  logic [GNT_W-1:0]  ptr_reg, gnt_reg, win_idx;
  logic [DATA_W-1:0] data_reg, win_data;
  logic              xfer_req_reg;
  logic [NUM_REQ-1:0] ready_reg;
  logic              win_found, grant_now, ack_now;
  int                cand;

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk_a),
    .rst_n (rst_a_n),
    .d     (bus.xfer_ack),
    .q     (ack_s)
  );

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_reg) + k) % NUM_REQ;
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = GNT_W'(cand);
        win_data  = bus.req_data[cand*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    grant_now  = 1'b0;
    ack_now    = 1'b0;
    case (state_reg)
      ST_IDLE: if (win_found && !ack_s) begin
        state_next = ST_REQ;
        grant_now  = 1'b1;
      end
      ST_REQ: if (ack_s) begin
        state_next = ST_DROP;
        ack_now    = 1'b1;
      end
      ST_DROP: if (!ack_s) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      ptr_reg      <= GNT_W'(NUM_REQ - 1);
      gnt_reg      <= '0;
      data_reg     <= '0;
      xfer_req_reg <= 1'b0;
      ready_reg    <= '0;
    end else begin
      ready_reg <= '0;
      if (grant_now) begin
        ptr_reg      <= win_idx;
        gnt_reg      <= win_idx;
        data_reg     <= win_data;
        xfer_req_reg <= 1'b1;
      end
      if (ack_now) begin
        ready_reg    <= NUM_REQ'(1) << gnt_reg;
        xfer_req_reg <= 1'b0;
      end
    end
  end

  assign bus.req_ready = ready_reg;
  assign bus.xfer_req  = xfer_req_reg;
  assign bus.xfer_data = data_reg;
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.grant_idx = gnt_reg;

`ifdef CDC_XFER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_reg, tmo_inc;
  logic                 tmo_err_reg;

  assign tmo_inc = tmo_reg + TIMEOUT_W'(1);

  // Saturating wait counter; restarts whenever a waiting state is entered.
  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      tmo_reg     <= '0;
      tmo_err_reg <= 1'b0;
    end else if ((state_next != state_reg) && (state_next != ST_IDLE)) begin
      tmo_reg <= '0;
    end else if ((state_reg != ST_IDLE) && !(&tmo_reg)) begin
      tmo_reg <= tmo_inc;
      if (&tmo_inc) tmo_err_reg <= 1'b1;
    end
  end

  assign bus.timeout_err = tmo_err_reg;
`else
  // Watchdog absent: flag is constant zero for any legal TIMEOUT_W.
  assign bus.timeout_err = (TIMEOUT_W < 1);
`endif

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Self-checking bench: cycle model of the arbitration rules plus directed scenarios.
module tb_cdc_xfer_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TW = 4;

  logic clk_a = 1'b0;
  logic rst_a_n = 1'b1;
  logic chk_en = 1'b0;
  logic auto_ack = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  cdc_xfer_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus();

  cdc_xfer_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_W(TW)
  ) dut (
    .clk_a   (clk_a),
    .rst_a_n (rst_a_n),
    .bus     (bus)
  );

  always #5 clk_a = ~clk_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: phase 0 idle, 1 waiting for ack, 2 waiting for ack release.
  logic         m_req, m_err;
  logic [DW-1:0] m_data;
  logic [NR-1:0] m_ready;
  int           m_gnt, m_last, m_phase, m_tcnt;
  logic         m_hist [0:SS-1];

  always @(posedge clk_a or negedge rst_a_n) begin
    logic acks;
    int t_phase, t_gnt, t_tcnt;
    logic t_err;
    if (!rst_a_n) begin
      m_req <= 1'b0; m_data <= '0; m_ready <= '0; m_gnt <= 0;
      m_last <= NR - 1; m_phase <= 0; m_tcnt <= 0; m_err <= 1'b0;
      for (int k = 0; k < SS; k++) m_hist[k] <= 1'b0;
    end else begin
      acks = m_hist[SS-1];   // xfer_ack as sampled SS edges earlier
      t_phase = m_phase; t_gnt = m_gnt; t_tcnt = m_tcnt; t_err = m_err;
      m_ready <= '0;
      if (m_phase == 0) begin
        if (bus.req_valid != 0 && !acks) begin
          for (int k = 1; k <= NR; k++) begin
            if (bus.req_valid[(m_last + k) % NR]) begin
              t_gnt = (m_last + k) % NR;
              break;
            end
          end
          m_gnt <= t_gnt; m_last <= t_gnt;
          m_data <= bus.req_data[t_gnt*DW +: DW];
          m_req <= 1'b1; t_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (acks) begin
          m_ready <= NR'(1) << m_gnt;
          m_req <= 1'b0; t_phase = 2;
        end
      end else if (!acks) begin
        t_phase = 0;
      end
`ifdef CDC_XFER_TIMEOUT_EN
      if (t_phase != m_phase && t_phase != 0) t_tcnt = 0;
      else if (m_phase != 0 && t_tcnt < (1 << TW) - 1) begin
        t_tcnt = t_tcnt + 1;
        if (t_tcnt == (1 << TW) - 1) t_err = 1'b1;
      end
`endif
      m_phase <= t_phase; m_tcnt <= t_tcnt; m_err <= t_err;
      for (int k = SS - 1; k > 0; k--) m_hist[k] <= m_hist[k-1];
      m_hist[0] <= bus.xfer_ack;
    end
  end

  always @(negedge clk_a) begin
    if (chk_en) begin
      check("xfer_req",    bus.xfer_req,    m_req);
      check("xfer_data",   bus.xfer_data,   m_data);
      check("req_ready",   bus.req_ready,   m_ready);
      check("busy",        bus.busy,        m_phase != 0);
      check("grant_idx",   bus.grant_idx,   m_gnt[1:0]);
      check("timeout_err", bus.timeout_err, m_err);
    end
  end

  // clk_b responder: acks 3 cycles after xfer_req rises, releases 3 cycles after it falls.
  initial begin
    int cnt;
    cnt = 0;
    bus.xfer_ack = 1'b0;
    forever begin
      @(posedge clk_a); #1;
      if (auto_ack) begin
        if (bus.xfer_req !== bus.xfer_ack) begin
          cnt++;
          if (cnt >= 3) begin bus.xfer_ack = bus.xfer_req; cnt = 0; end
        end else cnt = 0;
      end
    end
  end

  task automatic wait_ready(output logic [1:0] g, output logic [DW-1:0] d, output logic [NR-1:0] r);
    int n;
    n = 0;
    do begin @(negedge clk_a); n++; end while (bus.req_ready == 0 && n < 200);
    check("ready_seen", bus.req_ready != 0, 1);
    g = bus.grant_idx; d = bus.xfer_data; r = bus.req_ready;
    $display("transfer: grant=%0d data=%02h ready=%b", g, d, r);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk_a); n++; end while (bus.busy !== 1'b0 && n < 200);
    check("idle_reached", bus.busy, 0);
  endtask

  task automatic wait_xreq();
    int n;
    n = 0;
    do begin @(negedge clk_a); n++; end while (bus.xfer_req !== 1'b1 && n < 200);
    check("xfer_req_rise", bus.xfer_req, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk_a); #2 rst_a_n = 1'b0;
    @(negedge clk_a); @(negedge clk_a); #2 rst_a_n = 1'b1;
  endtask

  logic [1:0]    g;
  logic [DW-1:0] d;
  logic [NR-1:0] r;
  logic [1:0]    exp_g [0:4];
  logic [DW-1:0] exp_d [0:4];

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    #3 rst_a_n = 1'b0;
    #2 chk_en = 1'b1;
    @(negedge clk_a); #1;
    check("rst_xfer_req", bus.xfer_req, 0);
    check("rst_busy",     bus.busy, 0);
    check("rst_grant",    bus.grant_idx, 0);
    check("rst_ready",    bus.req_ready, 0);
    check("rst_data",     bus.xfer_data, 0);
    @(negedge clk_a); #2 rst_a_n = 1'b1;

    // Single request
    bus.req_data[7:0] = 8'hA5;
    bus.req_valid = 4'b0001;
    wait_ready(g, d, r);
    bus.req_valid = '0;
    check("single_grant", g, 0);
    check("single_data",  d, 8'hA5);
    check("single_ready", r, 4'b0001);
    @(negedge clk_a);
    check("single_ready_pulse", bus.req_ready, 0);
    wait_idle();

    // Fairness from a fresh pointer
    pulse_reset();
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req_valid = 4'b1111;
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    for (int i = 0; i < 5; i++) begin
      wait_ready(g, d, r);
      check("rr_grant", g, exp_g[i]);
      check("rr_data",  d, exp_d[i]);
    end
    bus.req_valid = '0;
    wait_idle();

    // Skip and wrap: last grant 2, then requesters 0 and 1
    bus.req_valid = 4'b0100;
    wait_ready(g, d, r);
    check("skip_grant2", g, 2);
    bus.req_valid = '0;
    wait_idle();
    bus.req_valid = 4'b0011;
    wait_ready(g, d, r);
    check("wrap_grant0", g, 0);
    bus.req_valid = 4'b0010;
    wait_ready(g, d, r);
    check("wrap_grant1", g, 1);
    check("wrap_data1",  d, 8'h22);
    bus.req_valid = '0;
    wait_idle();

    // Data sampled only at grant
    bus.req_data[7:0] = 8'h5A;
    bus.req_valid = 4'b0001;
    wait_xreq();
    check("stable_first", bus.xfer_data, 8'h5A);
    bus.req_data[7:0] = 8'hC3;
    @(negedge clk_a); @(negedge clk_a);
    check("stable_held", bus.xfer_data, 8'h5A);
    wait_ready(g, d, r);
    check("stable_ready_data", d, 8'h5A);
    bus.req_valid = '0;
    wait_idle();
    bus.req_valid = 4'b0001;
    wait_ready(g, d, r);
    check("stable_next_data", d, 8'hC3);
    bus.req_valid = '0;
    wait_idle();

    // Reset mid-transfer while clk_b is still acknowledging
    auto_ack = 1'b0;
    bus.req_data[7:0] = 8'h77;
    bus.req_valid = 4'b0001;
    wait_xreq();
    bus.xfer_ack = 1'b1;
    @(negedge clk_a); #2 rst_a_n = 1'b0;
    #1;
    check("midrst_xfer_req", bus.xfer_req, 0);
    check("midrst_busy",     bus.busy, 0);
    bus.req_valid = '0;
    @(negedge clk_a); @(negedge clk_a); #2 rst_a_n = 1'b1;
    repeat (3) @(negedge clk_a);
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_a);
      check("ack_gate_no_grant", bus.xfer_req, 0);
    end
    bus.xfer_ack = 1'b0;
    wait_xreq();
    check("resume_grant", bus.grant_idx, 0);
    check("resume_data",  bus.xfer_data, 8'h77);
    auto_ack = 1'b1;
    wait_ready(g, d, r);
    bus.req_valid = '0;
    wait_idle();

    // No acknowledge: handshake keeps waiting
    auto_ack = 1'b0;
    bus.req_valid = 4'b0010;
    wait_xreq();
    repeat (14) @(negedge clk_a);
    check("tmo_before", bus.timeout_err, 0);
    @(negedge clk_a);
`ifdef CDC_XFER_TIMEOUT_EN
    check("tmo_set", bus.timeout_err, 1);
    repeat (10) @(negedge clk_a);
    check("tmo_sticky", bus.timeout_err, 1);
`else
    check("tmo_absent", bus.timeout_err, 0);
    repeat (10) @(negedge clk_a);
    check("tmo_absent_late", bus.timeout_err, 0);
`endif
    check("tmo_req_held", bus.xfer_req, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
